uart_tx_serializer: RTL and testbench

//   Transmit path of the UART16550: accepts bytes from the register block's THR (tx_data/write_flag),

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 54 +++++
 rtl/uart_tx_serializer.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, word-length codes,
// LCR parity field indices and the frame parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] WL_5 = 2'b00;
    localparam logic [1:0] WL_6 = 2'b01;
    localparam logic [1:0] WL_7 = 2'b10;
    localparam logic [1:0] WL_8 = 2'b11;

    localparam int PAR_EN    = 0;
    localparam int PAR_EVEN  = 1;
    localparam int PAR_STICK = 2;

    // Only the data bits actually sent for this word length contribute to parity.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] wl,
                                        input logic [2:0] par);
        logic [7:0] mask;
        mask = 8'hFF;
        case (wl)
            WL_5: mask = 8'h1F;
            WL_6: mask = 8'h3F;
            WL_7: mask = 8'h7F;
            WL_8: mask = 8'hFF;
        endcase
        if (par[PAR_STICK]) begin
            return ~par[PAR_EVEN];
        end
        return par[PAR_EVEN] ? ^(data & mask) : ~^(data & mask);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit buffer (used when UART_TX_FIFO_EN is defined).
// A pop in the same cycle as a push on a full FIFO frees the slot the push lands in.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign rdata   = mem[rd_ptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART16550 transmit path: THR buffer, bit timer, LCR-formatted frame FSM and txd register.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [7:0]  tx_data,
    input  logic        write_flag,
    input  logic [1:0]  word_length,
    input  logic        stop_bits,
    input  logic [2:0]  parity,
    input  logic        set_break,
    input  logic [15:0] baud_rate_cnt,
    output logic        txd,
    output logic        thr_empty,
    output logic        tsr_empty,
    output logic        tx_overflow
);
    tx_state_t   state, state_next;
    logic [15:0] timer, timer_next;
    logic [7:0]  shreg, shreg_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [1:0]  wl_q;
    logic [2:0]  par_q;
    logic        stop_q;
    logic        par_bit;
    logic [7:0]  buf_data;
    logic        buf_full, buf_empty;
    logic        push, pop, run, tick, line;

    assign run  = (baud_rate_cnt != 16'd0);
    assign tick = run && (timer == 16'd0);
    assign push = write_flag && (!buf_full || pop);

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (PCLK),
        .rst   (PRESET),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (buf_data),
        .full  (buf_full),
        .empty (buf_empty)
    );
`else
    logic       hold_valid;
    logic [7:0] hold_data;
    logic       unused_depth;

    assign unused_depth = (FIFO_DEPTH > 1);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'd0;
        end else if (push) begin
            hold_data  <= tx_data;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_data  = hold_data;
    assign buf_full  = hold_valid;
    assign buf_empty = ~hold_valid;
`endif

    // A zero baud count freezes everything, including the pop out of IDLE.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        pop          = 1'b0;
        line         = 1'b1;
        case (state)
            IDLE: if (run && !buf_empty) begin
                pop        = 1'b1;
                state_next = START;
            end
            START: if (tick) begin
                state_next   = DATA;
                bit_cnt_next = 3'd0;
            end
            DATA: if (tick) begin
                shreg_next = {1'b0, shreg[7:1]};
                if (bit_cnt == {1'b0, wl_q} + 3'd4) begin
                    bit_cnt_next = 3'd0;
                    state_next   = par_q[PAR_EN] ? PARITY : STOP;
                end else begin
                    bit_cnt_next = bit_cnt + 3'd1;
                end
            end
            PARITY: if (tick) begin
                state_next   = STOP;
                bit_cnt_next = 3'd0;
            end
            STOP: if (tick) begin
                if (bit_cnt == {2'b00, stop_q}) begin
                    if (!buf_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) shreg_next = buf_data;

        if (run) begin
            if (tick || pop) begin
                timer_next = baud_rate_cnt - 16'd1;
            end else if (state != IDLE) begin
                timer_next = timer - 16'd1;
            end
        end

        // txd follows the state being entered so START appears on the pop edge.
        case (state_next)
            START:   line = 1'b0;
            DATA:    line = shreg_next[0];
            PARITY:  line = par_bit;
            default: line = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            timer       <= 16'd0;
            shreg       <= 8'd0;
            bit_cnt     <= 3'd0;
            wl_q        <= WL_5;
            par_q       <= 3'd0;
            stop_q      <= 1'b0;
            par_bit     <= 1'b0;
            txd         <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            if (pop) begin
                wl_q    <= word_length;
                par_q   <= parity;
                stop_q  <= stop_bits;
                par_bit <= parity_bit(buf_data, word_length, parity);
            end
            txd         <= set_break ? 1'b0 : line;
            tx_overflow <= write_flag && buf_full && !pop;
        end
    end

    assign thr_empty = buf_empty;
    assign tsr_empty = buf_empty && (state == IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a waveform-level frame model checked every cycle,
// plus literal frame vectors for the reference cases.
module tb_uart_tx_serializer;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [7:0]  tx_data;
    logic        write_flag;
    logic [1:0]  word_length;
    logic        stop_bits;
    logic [2:0]  parity;
    logic        set_break;
    logic [15:0] baud_rate_cnt;
    logic        txd, thr_empty, tsr_empty, tx_overflow;

    always #5 PCLK = ~PCLK;

    uart_tx_serializer #(.FIFO_DEPTH(16)) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .tx_data       (tx_data),
        .write_flag    (write_flag),
        .word_length   (word_length),
        .stop_bits     (stop_bits),
        .parity        (parity),
        .set_break     (set_break),
        .baud_rate_cnt (baud_rate_cnt),
        .txd           (txd),
        .thr_empty     (thr_empty),
        .tsr_empty     (tsr_empty),
        .tx_overflow   (tx_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one slot per cycle, {first slot of a frame, inside a frame, txd}.
    logic [2:0] exp_q[$];
    int         pend;
    int         frame_baud;
    logic       exp_ovf, cur_frame, line_exp, brk_q, model_on;
    logic [2:0] slot;
    logic       trace_q[$];
    logic       rec_on;
    int         ovf_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        pend      = 0;
        exp_ovf   = 1'b0;
        cur_frame = 1'b0;
        line_exp  = 1'b1;
    endtask

    // Frame = start, active data bits LSB first, optional parity, 1 or 2 stops.
    task automatic model_write(input logic [7:0] b);
        logic bits[$];
        int   nd, ones;
        logic pb, popping;
        popping = (baud_rate_cnt != 16'd0) && (exp_q.size() > 0) && exp_q[0][2];
        if (pend >= DEPTH && !popping) begin
            exp_ovf = 1'b1;
        end else begin
            nd   = int'(word_length) + 5;
            ones = 0;
            bits.push_back(1'b0);
            for (int i = 0; i < nd; i++) begin
                bits.push_back(b[i]);
                ones += int'(b[i]);
            end
            if (parity[0]) begin
                if (parity[2])      pb = !parity[1];
                else if (parity[1]) pb = (ones % 2) == 1;
                else                pb = (ones % 2) == 0;
                bits.push_back(pb);
            end
            bits.push_back(1'b1);
            if (stop_bits) bits.push_back(1'b1);
            if (exp_q.size() == 0) exp_q.push_back(3'b001);
            foreach (bits[k]) begin
                for (int r = 0; r < frame_baud; r++) begin
                    exp_q.push_back({(k == 0 && r == 0), 1'b1, bits[k]});
                end
            end
            pend++;
        end
    endtask

    always @(posedge PCLK) brk_q <= set_break;

    always @(negedge PCLK) begin
        if (rec_on) trace_q.push_back(txd);
        if (tx_overflow === 1'b1) ovf_seen++;
    end

    always @(negedge PCLK) begin
        if (model_on) begin
            if (baud_rate_cnt != 16'd0) begin
                if (exp_q.size() > 0) begin
                    slot = exp_q.pop_front();
                    if (slot[2]) pend--;
                    cur_frame = slot[1];
                    line_exp  = slot[0];
                end else begin
                    cur_frame = 1'b0;
                    line_exp  = 1'b1;
                end
            end
            check("txd", 32'(txd), 32'(brk_q ? 1'b0 : line_exp));
            check("thr_empty", 32'(thr_empty), 32'(pend == 0));
            check("tsr_empty", 32'(tsr_empty), 32'((pend == 0) && !cur_frame));
            check("tx_overflow", 32'(tx_overflow), 32'(exp_ovf));
            exp_ovf = 1'b0;
        end
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic write_byte(input logic [7:0] b);
        tx_data    = b;
        write_flag = 1'b1;
        @(posedge PCLK); #1;
        write_flag = 1'b0;
        model_write(b);
    endtask

    task automatic send_and_check(input string name, input logic [7:0] b, input int nb,
                                  input logic [15:0] lit);
        int          bd;
        int          idx;
        logic [15:0] got;
        bd         = int'(baud_rate_cnt);
        frame_baud = bd;
        write_byte(b);
        trace_q.delete();
        rec_on = 1'b1;
        repeat (bd * nb + 4) @(posedge PCLK);
        #1;
        rec_on = 1'b0;
        got = '0;
        for (int k = 0; k < nb; k++) begin
            idx = 1 + bd * k + bd / 2;
            got[k] = (idx < trace_q.size()) ? trace_q[idx] : 1'bx;
        end
        check(name, 32'(got), 32'(lit));
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        do begin
            @(posedge PCLK); #1;
            c++;
        end while (!(tsr_empty === 1'b1 && exp_q.size() == 0) && c < budget);
        check("drain_in_budget", 32'(tsr_empty), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf0, lows;
        PRESET = 1'b1; tx_data = 8'd0; write_flag = 1'b0;
        word_length = 2'b11; stop_bits = 1'b0; parity = 3'b000;
        set_break = 1'b0; baud_rate_cnt = 16'd4;
        model_on = 1'b0; rec_on = 1'b0; ovf_seen = 0; frame_baud = 4;
        model_flush();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_thr_empty", 32'(thr_empty), 32'd1);
        check("reset_tsr_empty", 32'(tsr_empty), 32'd1);
        check("reset_tx_overflow", 32'(tx_overflow), 32'd0);
        @(posedge PCLK); #1;
        PRESET   = 1'b0;
        model_on = 1'b1;
        @(posedge PCLK); #1;

        // 8N1, 4 cycles per bit
        send_and_check("frame_8n1_55", 8'h55, 10, 16'b1010101010);
        check("latency_idle_n1", 32'(trace_q[0]), 32'd1);
        check("latency_start_n2", 32'(trace_q[1]), 32'd0);
        check("stop_last_cycle", 32'(trace_q[40]), 32'd1);
        check("tsr_after_stop", 32'(tsr_empty), 32'd1);

        // 7 data bits, even then odd parity
        baud_rate_cnt = 16'd2; word_length = 2'b10; parity = 3'b011;
        send_and_check("frame_7e1_03", 8'h03, 10, 16'b1000000110);
        parity = 3'b001;
        send_and_check("frame_7o1_03", 8'h03, 10, 16'b1100000110);

        // 5 data bits, stick parity, 2 stop bits
        word_length = 2'b00; stop_bits = 1'b1; parity = 3'b111;
        send_and_check("frame_5s2_stick0", 8'h0A, 9, 16'b110010100);
        parity = 3'b101;
        send_and_check("frame_5s2_stick1", 8'h0A, 9, 16'b111010100);

        // Buffer full while the line is frozen
        word_length = 2'b11; stop_bits = 1'b0; parity = 3'b000;
        baud_rate_cnt = 16'd0; frame_baud = 2;
        @(posedge PCLK); #1;
        ovf0 = ovf_seen;
        for (int i = 0; i < DEPTH + 2; i++) write_byte(8'(i * 37 + 5));
        @(posedge PCLK); #1;
        check("overflow_pulses", 32'(ovf_seen - ovf0), 32'd2);
        baud_rate_cnt = 16'd2;
        wait_idle((DEPTH + 2) * 25 + 20);

        // Break asserted mid-DATA
        baud_rate_cnt = 16'd4; frame_baud = 4;
        write_byte(8'h0F);
        repeat (12) @(posedge PCLK);
        #1;
        set_break = 1'b1;
        lows = 0;
        repeat (10) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (txd === 1'b0) lows++;
        end
        @(posedge PCLK); #1;
        set_break = 1'b0;
        check("break_low_cycles", 32'(lows), 32'd10);
        wait_idle(100);

        // Reset mid-frame, then a clean frame
        write_byte(8'hF0);
        repeat (10) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        model_flush();
        @(negedge PCLK);
        check("midreset_txd", 32'(txd), 32'd1);
        check("midreset_thr_empty", 32'(thr_empty), 32'd1);
        check("midreset_tsr_empty", 32'(tsr_empty), 32'd1);
        @(posedge PCLK); #1;
        send_and_check("frame_after_reset", 8'hA5, 10, 16'b1101001010);

        repeat (4) @(posedge PCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
